// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared defaults and types for the integer register file and its scoreboard.
//   XLEN       default register width
//   NREGS      default architectural register count
//   AW         default register address width
//   reg_addr_t register index type for the default configuration
//   REG_*      ABI register indices
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef logic [AW-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = reg_addr_t'(0);
  localparam reg_addr_t REG_RA   = reg_addr_t'(1);
  localparam reg_addr_t REG_SP   = reg_addr_t'(2);

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Per-register pending-write tracking. A reservation marks a register busy;
// a writeback to it clears the mark. When both hit the same register in one
// cycle the reservation wins, since it stands for a newer producer.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rsv_valid, rsv_addr     reserve request
//   we, rd_addr             writeback release
//   busy_o                  busy vector (bit 0 is always 0)
//   busy_count              number of busy registers, registered with busy_o
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = regfile_pkg::NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rsv_valid,
  input  logic [AW-1:0]    rsv_addr,
  input  logic             we,
  input  logic [AW-1:0]    rd_addr,
  output logic [NREGS-1:0] busy_o,
  output logic [AW:0]      busy_count
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    busy_d = busy_q;
    if (we && (rd_addr != '0))
      busy_d[rd_addr] = 1'b0;
    // Applied after the release so a same-register reserve stays set.
    if (rsv_valid && (rsv_addr != '0))
      busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Count is derived from the next-state vector so it tracks busy_q exactly.
  always_comb begin
    count_d = '0;
    for (int i = 1; i < NREGS; i++)
      count_d = count_d + (AW+1)'(busy_d[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_count = count_q;

endmodule

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// Integer register file: two combinational read ports, one clocked write
// port, x0 hardwired to zero, plus a pending-write scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN forwards same-cycle write data
// to the read ports and reports the written register as not busy.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   rs1_addr/rs2_addr            read addresses
//   rs1_data/rs2_data            read data
//   rs1_busy/rs2_busy            addressed register has a pending write
//   we, rd_addr, rd_data         write port (also releases busy)
//   rsv_valid, rsv_addr          reserve register as pending
//   busy_count                   number of reserved registers
// -----------------------------------------------------------------------------
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter  int XLEN  = regfile_pkg::XLEN,
  parameter  int NREGS = regfile_pkg::NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            we,
  input  logic [AW-1:0]   rd_addr,
  input  logic [XLEN-1:0] rd_data,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_addr,
  output logic [AW:0]     busy_count
);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NREGS-1:0] busy;
  logic             wr_en;

  assign wr_en = we && (rd_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[rd_addr] <= rd_data;
    end
  end

  regfile_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .we         (we),
    .rd_addr    (rd_addr),
    .busy_o     (busy),
    .busy_count (busy_count)
  );

  logic rs1_hit, rs2_hit;

`ifdef REGFILE_BYPASS_EN
  assign rs1_hit = wr_en && (rs1_addr == rd_addr);
  assign rs2_hit = wr_en && (rs2_addr == rd_addr);
`else
  assign rs1_hit = 1'b0;
  assign rs2_hit = 1'b0;
`endif

  // A forwarded register reads as not busy even if a same-cycle reserve
  // targets it; that reservation only shows after the edge.
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    if (rs1_addr != '0) begin
      rs1_data = rs1_hit ? rd_data : mem_q[rs1_addr];
      rs1_busy = rs1_hit ? 1'b0    : busy[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (rs2_addr != '0) begin
      rs2_data = rs2_hit ? rd_data : mem_q[rs2_addr];
      rs2_busy = rs2_hit ? 1'b0    : busy[rs2_addr];
    end
  end

endmodule
